// File: rtl/float_mult_pipe.sv
// Pipelined floating-point multiplier: round-to-nearest-even, special-case handling, valid/ready flow control.
// Operand register, then classify/multiply, normalise, and round/pack stages; one global advance enable.
module float_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] x,
    input  logic [EXP_W+MAN_W:0] y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 zero,
    output logic                 underflow,
    output logic                 overflow,
    output logic                 nan
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS   = EW'((32'sd1 <<< (EXP_W - 1)) - 32'sd1);
    localparam logic signed [EW-1:0] E_MAX  = EW'((32'sd1 <<< EXP_W) - 32'sd1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(32'sd1);
    localparam logic signed [EW-1:0] E_ZERO = EW'(32'sd0);

    logic                 en_s;
    logic                 v0_r, v1_r, v2_r;
    logic [W-1:0]         x_r, y_r;
    logic [EXP_W-1:0]     ex_s, ey_s;
    logic [MAN_W-1:0]     fx_s, fy_s;
    logic                 x_zero_s, x_inf_s, x_nan_s, y_zero_s, y_inf_s, y_nan_s;
    logic                 sign1_r, nan1_r, inf1_r, zero1_r;
    logic signed [EW-1:0] esum1_r;
    logic [PW-1:0]        prod1_r;
    logic signed [EW-1:0] e2_s, e2_r;
    logic [MAN_W-1:0]     frac2_s, frac2_r;
    logic                 guard2_s, sticky2_s, guard2_r, sticky2_r;
    logic                 sign2_r, nan2_r, inf2_r, zero2_r;
    logic                 round_up_s;
    logic [MAN_W:0]       frac_sum_s;
    logic signed [EW-1:0] e3_s;
    logic [W-1:0]         result_s;
    logic                 zero_s, underflow_s, overflow_s, nan_s;

    // A stalled output freezes every stage, so in_ready is the shared advance enable.
    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    assign ex_s     = x_r[W-2:MAN_W];
    assign ey_s     = y_r[W-2:MAN_W];
    assign fx_s     = x_r[MAN_W-1:0];
    assign fy_s     = y_r[MAN_W-1:0];
    assign x_zero_s = (ex_s == {EXP_W{1'b0}});
    assign y_zero_s = (ey_s == {EXP_W{1'b0}});
    assign x_inf_s  = (ex_s == {EXP_W{1'b1}}) && (fx_s == {MAN_W{1'b0}});
    assign y_inf_s  = (ey_s == {EXP_W{1'b1}}) && (fy_s == {MAN_W{1'b0}});
    assign x_nan_s  = (ex_s == {EXP_W{1'b1}}) && (fx_s != {MAN_W{1'b0}});
    assign y_nan_s  = (ey_s == {EXP_W{1'b1}}) && (fy_s != {MAN_W{1'b0}});

    // Operand capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0_r <= 1'b0;
            x_r  <= {W{1'b0}};
            y_r  <= {W{1'b0}};
        end else if (en_s) begin
            v0_r <= in_valid;
            x_r  <= x;
            y_r  <= y;
        end
    end

    // Classify operands, sum exponents and multiply significands (denormals flushed to zero).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_r    <= 1'b0;
            sign1_r <= 1'b0;
            nan1_r  <= 1'b0;
            inf1_r  <= 1'b0;
            zero1_r <= 1'b0;
            esum1_r <= E_ZERO;
            prod1_r <= {PW{1'b0}};
        end else if (en_s) begin
            v1_r    <= v0_r;
            sign1_r <= x_r[W-1] ^ y_r[W-1];
            nan1_r  <= x_nan_s | y_nan_s | (x_inf_s & y_zero_s) | (x_zero_s & y_inf_s);
            inf1_r  <= x_inf_s | y_inf_s;
            zero1_r <= x_zero_s | y_zero_s;
            esum1_r <= $signed({2'b00, ex_s}) + $signed({2'b00, ey_s});
            prod1_r <= PW'({1'b1, fx_s}) * PW'({1'b1, fy_s});
        end
    end

    // Normalise: the significand product lies in [1,4), so at most one right shift is needed.
    always_comb begin
        frac2_s   = {MAN_W{1'b0}};
        guard2_s  = 1'b0;
        sticky2_s = 1'b0;
        e2_s      = esum1_r - BIAS;
        if (prod1_r[PW-1]) begin
            frac2_s   = prod1_r[PW-2 -: MAN_W];
            guard2_s  = prod1_r[PW-2-MAN_W];
            sticky2_s = |prod1_r[PW-3-MAN_W:0];
            e2_s      = esum1_r - BIAS + E_ONE;
        end else begin
            frac2_s   = prod1_r[PW-3 -: MAN_W];
            guard2_s  = prod1_r[PW-3-MAN_W];
            sticky2_s = |prod1_r[PW-4-MAN_W:0];
            e2_s      = esum1_r - BIAS;
        end
    end

    // Normalised-stage register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_r      <= 1'b0;
            sign2_r   <= 1'b0;
            nan2_r    <= 1'b0;
            inf2_r    <= 1'b0;
            zero2_r   <= 1'b0;
            e2_r      <= E_ZERO;
            frac2_r   <= {MAN_W{1'b0}};
            guard2_r  <= 1'b0;
            sticky2_r <= 1'b0;
        end else if (en_s) begin
            v2_r      <= v1_r;
            sign2_r   <= sign1_r;
            nan2_r    <= nan1_r;
            inf2_r    <= inf1_r;
            zero2_r   <= zero1_r;
            e2_r      <= e2_s;
            frac2_r   <= frac2_s;
            guard2_r  <= guard2_s;
            sticky2_r <= sticky2_s;
        end
    end

    // Round to nearest even, then pack with special cases taking priority over range checks.
    always_comb begin
        round_up_s  = guard2_r & (sticky2_r | frac2_r[0]);
        frac_sum_s  = {1'b0, frac2_r} + {{MAN_W{1'b0}}, round_up_s};
        e3_s        = frac_sum_s[MAN_W] ? (e2_r + E_ONE) : e2_r;
        zero_s      = 1'b0;
        underflow_s = 1'b0;
        overflow_s  = 1'b0;
        nan_s       = 1'b0;
        if (nan2_r) begin
            result_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            nan_s    = 1'b1;
        end else if (inf2_r) begin
            result_s = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero2_r) begin
            result_s = {sign2_r, {(W-1){1'b0}}};
            zero_s   = 1'b1;
        end else if (e3_s >= E_MAX) begin
            result_s   = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow_s = 1'b1;
        end else if (e3_s <= E_ZERO) begin
            result_s    = {sign2_r, {(W-1){1'b0}}};
            underflow_s = 1'b1;
            zero_s      = 1'b1;
        end else begin
            result_s = {sign2_r, e3_s[EXP_W-1:0], frac_sum_s[MAN_W-1:0]};
        end
    end

    // Output register: result and flags stay stable while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= {W{1'b0}};
            zero      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            nan       <= 1'b0;
        end else if (en_s) begin
            out_valid <= v2_r;
            result    <= result_s;
            zero      <= zero_s;
            underflow <= underflow_s;
            overflow  <= overflow_s;
            nan       <= nan_s;
        end
    end
endmodule

// File: tb/tb_float_mult_pipe.sv
// Bench for float_mult_pipe (single precision): directed vectors, randomized stream with backpressure,
// stall/ordering scenario and reset with operations in flight, against an arithmetic reference model.
module tb_float_mult_pipe;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, underflow, overflow, nan;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [35:0] exp_q[$];

    logic [31:0] dir_x [8] = '{32'h3FC00000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F000000,
                                32'h00800000, 32'h7F800000, 32'hFF800000, 32'h80000000};
    logic [31:0] dir_y [8] = '{32'h40000000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F000000,
                                32'h00800000, 32'h00000000, 32'h40000000, 32'h3F800000};
    // {zero, underflow, overflow, nan, result}
    logic [35:0] dir_exp [8] = '{36'h0_4040_0000, 36'h0_3F80_0002, 36'h0_407F_FFFE, 36'h2_7F80_0000,
                                  36'hC_0000_0000, 36'h1_7FC0_0000, 36'h0_FF80_0000, 36'h8_8000_0000};

    always #5 clk = ~clk;

    float_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .underflow(underflow), .overflow(overflow), .nan(nan)
    );

    // Reference: exact integer significand product, rounded by comparing the discarded remainder with one half.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s, za, zb, ia, ib, na, nb;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        if (na || nb || (ia && zb) || (za && ib)) return {4'b0001, 32'h7FC00000};
        if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
        if (za || zb) return {4'b1000, s, 31'd0};
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= 64'h8000_0000_0000) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == 64'h100_0000) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b1100, s, 31'd0};
        return {4'b0000, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] gen_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = $urandom;
            1: begin
                case ($urandom_range(0, 3))
                    0: r[30:0] = 31'd0;
                    1: r[30:0] = 31'h7F800000;
                    2: r[30:23] = 8'hFF;
                    default: r[30:23] = 8'h00;
                endcase
            end
            2: r[30:23] = 8'($urandom_range(1, 40));
            3: r[30:23] = 8'($urandom_range(200, 254));
            default: r[30:23] = 8'($urandom_range(90, 164));
        endcase
        return r;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = 32'd0; y = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        vec_cnt++;
        if ({out_valid, zero, underflow, overflow, nan, result} !== 37'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got valid=%b flags=%b%b%b%b result=%h, expected all zero",
                     out_valid, zero, underflow, overflow, nan, result);
        end
        reset_n = 1'b1;
        @(posedge clk); #2;
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [35:0] got_v;
        for (int i = 0; i < 8; i++) begin
            x = dir_x[i]; y = dir_y[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            vec_cnt++;
            if (in_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            @(posedge clk); #2;
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                vec_cnt++;
                if (out_valid !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL directed_latency[%0d]: out_valid=%b %0d edges after accept, expected 0", i, out_valid, k);
                end
                @(posedge clk); #2;
            end
            got_v = {zero, underflow, overflow, nan, result};
            vec_cnt++;
            if (out_valid !== 1'b1 || got_v !== dir_exp[i]) begin
                err_cnt++;
                $display("FAIL directed[%0d] %h*%h: got valid=%b {flags,result}=%h expected valid=1 %h",
                         i, dir_x[i], dir_y[i], out_valid, got_v, dir_exp[i]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_random(input int n_cycles);
        logic [35:0] got_v, exp_v;
        logic fired_in = 1'b0;
        exp_q.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < n_cycles; c++) begin
            if (!in_valid || fired_in) begin
                in_valid = ($urandom_range(0, 3) != 0);
                x = gen_op();
                y = gen_op();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            fired_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got_v = {zero, underflow, overflow, nan, result};
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL random_extra: unexpected result %h, expected none", got_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        err_cnt++;
                        $display("FAIL random_result: got %h expected %h", got_v, exp_v);
                    end
                end
            end
            if (fired_in) exp_q.push_back(ref_mul(x, y));
            @(posedge clk); #2;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            #1;
            if (out_valid) begin
                got_v = {zero, underflow, overflow, nan, result};
                exp_v = exp_q.pop_front();
                vec_cnt++;
                if (got_v !== exp_v) begin
                    err_cnt++;
                    $display("FAIL random_drain: got %h expected %h", got_v, exp_v);
                end
            end
            @(posedge clk); #2;
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL random_lost: %0d results missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops_x [8];
        logic [31:0] ops_y [8];
        logic [35:0] got_v, exp_v, held_v;
        logic held = 1'b0;
        logic saw_stall = 1'b0;
        int sent = 0;
        int got = 0;
        exp_q.delete();
        held_v = 36'd0;
        for (int i = 0; i < 8; i++) begin
            ops_x[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
            ops_y[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
        end
        for (int c = 1; c <= 40 && got < 8; c++) begin
            in_valid = (sent < 8);
            if (sent < 8) begin
                x = ops_x[sent];
                y = ops_y[sent];
            end
            out_ready = !(c >= 4 && c <= 8);
            #1;
            got_v = {zero, underflow, overflow, nan, result};
            if (held) begin
                vec_cnt++;
                if (out_valid !== 1'b1 || got_v !== held_v) begin
                    err_cnt++;
                    $display("FAIL stall_stable: got valid=%b %h expected valid=1 %h", out_valid, got_v, held_v);
                end
            end
            held   = out_valid && !out_ready;
            held_v = got_v;
            if (out_valid && !out_ready) begin
                saw_stall = 1'b1;
                vec_cnt++;
                if (in_ready !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                vec_cnt++;
                got++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL b2b_extra: unexpected result %h, expected none", got_v);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got_v !== exp_v) begin
                        err_cnt++;
                        $display("FAIL b2b_order: got %h expected %h", got_v, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(x, y));
                sent++;
            end
            @(posedge clk); #2;
        end
        vec_cnt++;
        if (sent != 8 || got != 8 || !saw_stall) begin
            err_cnt++;
            $display("FAIL b2b_count: sent=%0d received=%0d stalled=%b, expected 8 8 1", sent, got, saw_stall);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            vec_cnt++;
            if (out_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_duplicate: out_valid=%b after stream end, expected 0", out_valid);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset_inflight();
        exp_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x = {1'b0, 8'h7F, 23'($urandom)};
            y = {1'b0, 8'h80, 23'($urandom)};
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b1 || result === 32'd0) begin
            err_cnt++;
            $display("FAIL inflight_setup: got valid=%b result=%h, expected valid=1 and nonzero", out_valid, result);
        end
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if ({out_valid, zero, underflow, overflow, nan, result} !== 37'd0) begin
            err_cnt++;
            $display("FAIL inflight_reset: got valid=%b result=%h, expected 0 0", out_valid, result);
        end
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            vec_cnt++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                err_cnt++;
                $display("FAIL inflight_stale: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
            end
            @(posedge clk); #2;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(400);
        test_back_to_back();
        test_reset_inflight();
        test_random(200);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
